regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have input clk, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have input rst_n, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have input alu_valid, 1 bit: ALU result offered.
REQ-004 SHALL have output alu_ready, 1 bit: ALU result accepted this cycle when alu_valid and alu_ready are both high.
REQ-005 SHALL have input alu_rd, 5 bits, and input alu_data, 32 bits: ALU destination and result.
REQ-006 SHALL have input ld_valid, 1 bit: load result offered.
REQ-007 SHALL have output ld_ready, 1 bit: load result accepted this cycle when ld_valid and ld_ready are both high.
REQ-008 SHALL have input ld_rd, 5 bits, and input ld_data, 32 bits: load destination and data.
REQ-009 SHALL have input iss_valid, 1 bit, and input iss_rd, 5 bits: a load was issued with destination iss_rd.
REQ-010 SHALL have input rs1, 5 bits, and input rs2, 5 bits: decode-stage source register indices.
REQ-011 SHALL have output hazard, 1 bit: decode must stall.
REQ-012 SHALL have output busy, 32 bits: scoreboard, where bit n means register xn has a load pending.
REQ-013 SHALL have output RegWEn, 1 bit, output AddrD, 5 bits, and output DataD, 32 bits: register-file write port, all registered.
REQ-014 SHALL have output stall_cnt, 16 bits: count of cycles in which ALU acceptance was refused.

Function
REQ-015 SHALL hold ld_ready at 1 whenever rst_n is high, since loads are never back-pressured.
REQ-016 SHALL drive alu_ready = rst_n AND NOT ld_valid, combinationally, giving loads priority.
REQ-017 SHALL, on an edge with a load accepted, register RegWEn = (ld_rd != 0), AddrD = ld_rd, DataD = ld_data.
REQ-018 SHALL, on an edge with an ALU result accepted and no load accepted, register RegWEn = (alu_rd != 0), AddrD = alu_rd, DataD = alu_data.
REQ-019 SHALL, on an edge with nothing accepted, register RegWEn = 0 and hold AddrD and DataD.
REQ-020 SHALL give a latency of exactly 1 cycle from acceptance to RegWEn high, with at most one write per cycle.
REQ-021 SHALL complete the handshake for a destination of x0 but never assert RegWEn for it.
REQ-022 SHALL set busy[iss_rd] on the next edge when iss_valid is high and iss_rd != 0; iss_rd = 0 SHALL be ignored.
REQ-023 SHALL clear busy[ld_rd] on the edge the load is accepted.
REQ-024 SHALL let the set win when a set and a clear hit the same index on the same edge.
REQ-025 SHALL leave busy unchanged when iss_rd is set while its bit is already 1 (no pending count).
REQ-026 SHALL never let an ALU write change busy.
REQ-027 SHALL keep busy[0] at 0 at all times.
REQ-028 SHALL drive hazard combinationally as (rs1 != 0 AND busy[rs1]) OR (rs2 != 0 AND busy[rs2]).
REQ-029 SHALL compute hazard from the current busy register only; a load accepted in the same cycle does not remove the hazard until the next cycle.
REQ-030 SHALL increment stall_cnt by 1 on each edge where alu_valid AND ld_valid are both high.
REQ-031 SHALL saturate stall_cnt at 0xFFFF.
REQ-032 SHALL keep the ALU source's alu_rd and alu_data stable until acceptance; the block does not latch refused ALU data.

Reset
REQ-033 SHALL, on an edge with rst_n low, set RegWEn = 0, AddrD = 0, DataD = 0, busy = 0 and stall_cnt = 0.
REQ-034 SHALL force alu_ready = 0 and ld_ready = 0 while rst_n is low.
REQ-035 SHALL accept no handshake while rst_n is low.
REQ-036 SHALL, on reset mid-operation, discard pending scoreboard bits and any in-flight write; RegWEn is 0 on the first cycle after reset is released.

Verification
REQ-037 SHALL cover: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle RegWEn=1, AddrD=5, DataD=0xDEADBEEF.
REQ-038 SHALL cover: alu_valid=1 and ld_valid=1 in the same cycle (ld_rd=3, ld_data=0x11) -> alu_ready=0, next cycle AddrD=3, DataD=0x11, stall_cnt=1; the ALU result is written one cycle later.
REQ-039 SHALL cover: iss_valid=1, iss_rd=7, then rs1=7 -> busy[7]=1 and hazard=1; ld_valid=1, ld_rd=7 -> busy[7]=0 and hazard=0 on the following cycle.
REQ-040 SHALL cover: iss_rd=9 issued in the same cycle as a load accepted with ld_rd=9 -> busy[9] stays 1.
REQ-041 SHALL cover: alu_rd=0 with alu_valid=1 -> alu_ready=1 and RegWEn stays 0; iss_rd=0 -> busy stays 0.
REQ-042 SHALL cover: busy=0x00000084 and stall_cnt=0xFFFF, then rst_n=0 for one cycle -> busy=0, stall_cnt=0, RegWEn=0; separately, 0xFFFF plus one more collision -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-back arbiter for a register file with a load scoreboard.
//   Two producers compete for a single register-file write port: the ALU and
//   the load unit. Loads always win and are never back-pressured; a refused
//   ALU result is held by its source until accepted. A busy bit per register
//   tracks loads that have been issued but not yet written back, and decode
//   is told to stall when one of its sources is still pending.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
//   both high on that edge. ready never depends on the same source's data,
//   only on rst_n and (for the ALU) on ld_valid.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   alu_valid/ready       ALU result handshake, alu_rd/alu_data payload
//   ld_valid/ready        load result handshake, ld_rd/ld_data payload
//   iss_valid, iss_rd     load issued toward destination iss_rd
//   rs1, rs2              decode source registers
//   hazard                decode must stall
//   busy                  per-register load-pending scoreboard
//   RegWEn/AddrD/DataD    registered register-file write port
//   stall_cnt             saturating count of cycles the ALU was refused
module regfile_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
    output logic [31:0] busy,
    output logic        RegWEn,
    output logic [4:0]  AddrD,
    output logic [31:0] DataD,
    output logic [15:0] stall_cnt
);

    logic        regwen_q, regwen_d;
    logic [4:0]  addrd_q, addrd_d;
    logic [31:0] datad_q, datad_d;
    logic [31:0] busy_q, busy_d;
    logic [15:0] stall_q, stall_d;

    logic        ld_acc;
    logic        alu_acc;

    // Loads have priority, so the ALU is refused whenever a load is offered.
    assign ld_ready  = rst_n;
    assign alu_ready = rst_n & ~ld_valid;

    assign ld_acc  = ld_valid & ld_ready;
    assign alu_acc = alu_valid & alu_ready;

    // Hazard looks only at the registered scoreboard: a load being accepted
    // this cycle clears its bit on the edge, so the stall lifts next cycle.
    assign hazard = ((rs1 != 5'd0) && busy_q[rs1]) ||
                    ((rs2 != 5'd0) && busy_q[rs2]);

    always_comb begin
        regwen_d = 1'b0;
        addrd_d  = addrd_q;
        datad_d  = datad_q;
        if (ld_acc) begin
            regwen_d = (ld_rd != 5'd0);
            addrd_d  = ld_rd;
            datad_d  = ld_data;
        end else if (alu_acc) begin
            regwen_d = (alu_rd != 5'd0);
            addrd_d  = alu_rd;
            datad_d  = alu_data;
        end

        // Clear first, then set, so a new issue to the same register wins.
        busy_d = busy_q;
        if (ld_acc) begin
            busy_d[ld_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        stall_d = stall_q;
        if (alu_valid && ld_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwen_q <= 1'b0;
            addrd_q  <= 5'd0;
            datad_q  <= 32'd0;
            busy_q   <= 32'd0;
            stall_q  <= 16'd0;
        end else begin
            regwen_q <= regwen_d;
            addrd_q  <= addrd_d;
            datad_q  <= datad_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
        end
    end

    assign RegWEn    = regwen_q;
    assign AddrD     = addrd_q;
    assign DataD     = datad_q;
    assign busy      = busy_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: per-feature tasks with inline checks, plus a
// write-port monitor that pops expected writes from a queue.
module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic [31:0] busy;
    logic        RegWEn;
    logic [4:0]  AddrD;
    logic [31:0] DataD;
    logic [15:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [36:0] exp_q[$];
    logic [15:0] exp_stall = 16'd0;

    regfile_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard    (hazard),
        .busy      (busy),
        .RegWEn    (RegWEn),
        .AddrD     (AddrD),
        .DataD     (DataD),
        .stall_cnt (stall_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: every RegWEn pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (RegWEn === 1'b1) begin
            logic [36:0] e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got AddrD=%0d DataD=%h, expected no write", AddrD, DataD);
            end else begin
                e = exp_q.pop_front();
                if ({AddrD, DataD} !== e)
                    $display("FAIL write_port: got AddrD=%0d DataD=%h, expected AddrD=%0d DataD=%h",
                             AddrD, DataD, e[36:32], e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    // Drivers
    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    // Advance one clock; records the write expected from the handshake as driven.
    task automatic cycle();
        if (rst_n) begin
            if (ld_valid) begin
                if (ld_rd != 5'd0) exp_q.push_back({ld_rd, ld_data});
            end else if (alu_valid && alu_rd != 5'd0) begin
                exp_q.push_back({alu_rd, alu_data});
            end
            if (alu_valid && ld_valid && exp_stall != 16'hFFFF) exp_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'h2;
        iss_valid = 1'b1; iss_rd = 5'd6;
        cycle();
        cycle();
        n_total++; if (alu_ready !== 1'b0) $display("FAIL rst_alu_ready: got %b expected 0", alu_ready); else n_pass++;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %b expected 0", ld_ready); else n_pass++;
        n_total++; if (RegWEn !== 1'b0) $display("FAIL rst_regwen: got %b expected 0", RegWEn); else n_pass++;
        n_total++; if (AddrD !== 5'd0 || DataD !== 32'd0) $display("FAIL rst_addr_data: got %0d/%h expected 0/0", AddrD, DataD); else n_pass++;
        n_total++; if (busy !== 32'd0) $display("FAIL rst_busy: got %h expected 0", busy); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL rst_stall: got %h expected 0", stall_cnt); else n_pass++;
        drive_idle();
        rst_n = 1'b1;
        #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL ld_ready_run: got %b expected 1", ld_ready); else n_pass++;
        cycle();
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL alu_ready: got %b expected 1", alu_ready); else n_pass++;
        cycle();
        drive_idle();
        n_total++; if (RegWEn !== 1'b1 || AddrD !== 5'd5 || DataD !== 32'hDEADBEEF)
            $display("FAIL alu_write: got %b/%0d/%h expected 1/5/deadbeef", RegWEn, AddrD, DataD); else n_pass++;
        cycle();
        n_total++; if (RegWEn !== 1'b0 || AddrD !== 5'd5 || DataD !== 32'hDEADBEEF)
            $display("FAIL idle_hold: got %b/%0d/%h expected 0/5/deadbeef", RegWEn, AddrD, DataD); else n_pass++;
    endtask

    task automatic test_collision();
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA5A5A5A5;
        ld_valid  = 1'b1; ld_rd  = 5'd3;  ld_data  = 32'h11;
        #1;
        n_total++; if (alu_ready !== 1'b0 || ld_ready !== 1'b1)
            $display("FAIL coll_ready: got alu=%b ld=%b expected 0/1", alu_ready, ld_ready); else n_pass++;
        cycle();
        ld_valid = 1'b0;
        #1;
        n_total++; if (RegWEn !== 1'b1 || AddrD !== 5'd3 || DataD !== 32'h11)
            $display("FAIL coll_load_first: got %b/%0d/%h expected 1/3/11", RegWEn, AddrD, DataD); else n_pass++;
        n_total++; if (stall_cnt !== exp_stall) $display("FAIL coll_stall: got %h expected %h", stall_cnt, exp_stall); else n_pass++;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL coll_alu_ready: got %b expected 1", alu_ready); else n_pass++;
        cycle();
        drive_idle();
        n_total++; if (RegWEn !== 1'b1 || AddrD !== 5'd10 || DataD !== 32'hA5A5A5A5)
            $display("FAIL coll_alu_later: got %b/%0d/%h expected 1/10/a5a5a5a5", RegWEn, AddrD, DataD); else n_pass++;
        n_total++; if (stall_cnt !== 16'd1) $display("FAIL coll_stall_hold: got %h expected 1", stall_cnt); else n_pass++;
        cycle();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        iss_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        n_total++; if (busy !== 32'h80) $display("FAIL sb_set: got %h expected 00000080", busy); else n_pass++;
        n_total++; if (hazard !== 1'b1) $display("FAIL sb_hazard_rs1: got %b expected 1", hazard); else n_pass++;
        rs1 = 5'd6; rs2 = 5'd7;
        #1;
        n_total++; if (hazard !== 1'b1) $display("FAIL sb_hazard_rs2: got %b expected 1", hazard); else n_pass++;
        rs2 = 5'd8;
        #1;
        n_total++; if (hazard !== 1'b0) $display("FAIL sb_no_hazard: got %b expected 0", hazard); else n_pass++;
        // re-issue while pending: no count, a single load clears it
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        iss_valid = 1'b0;
        rs1 = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        #1;
        n_total++; if (hazard !== 1'b1) $display("FAIL sb_hazard_same_cycle: got %b expected 1", hazard); else n_pass++;
        cycle();
        ld_valid = 1'b0;
        #1;
        n_total++; if (busy !== 32'd0 || hazard !== 1'b0) $display("FAIL sb_clear: got busy=%h hazard=%b expected 0/0", busy, hazard); else n_pass++;
        // ALU write to a pending register leaves busy alone
        iss_valid = 1'b1; iss_rd = 5'd12;
        cycle();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0FFEE;
        cycle();
        alu_valid = 1'b0;
        n_total++; if (busy !== 32'h1000) $display("FAIL sb_alu_no_clear: got %h expected 00001000", busy); else n_pass++;
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h12;
        cycle();
        drive_idle();
        n_total++; if (busy !== 32'd0) $display("FAIL sb_clear12: got %h expected 0", busy); else n_pass++;
    endtask

    task automatic test_set_clear_same();
        iss_valid = 1'b1; iss_rd = 5'd9;
        cycle();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        cycle();
        drive_idle();
        n_total++; if (busy !== 32'h200) $display("FAIL set_wins: got %h expected 00000200", busy); else n_pass++;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9A;
        cycle();
        drive_idle();
        n_total++; if (busy !== 32'd0) $display("FAIL clear9: got %h expected 0", busy); else n_pass++;
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL x0_alu_ready: got %b expected 1", alu_ready); else n_pass++;
        cycle();
        alu_valid = 1'b0;
        n_total++; if (RegWEn !== 1'b0) $display("FAIL x0_alu_no_write: got %b expected 0", RegWEn); else n_pass++;
        iss_valid = 1'b1; iss_rd = 5'd0;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h5678;
        cycle();
        drive_idle();
        n_total++; if (busy !== 32'd0) $display("FAIL x0_busy: got %h expected 0", busy); else n_pass++;
        n_total++; if (RegWEn !== 1'b0) $display("FAIL x0_ld_no_write: got %b expected 0", RegWEn); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 2) == 0);
            ld_rd     = 5'($urandom_range(0, 31));
            ld_data   = $urandom;
            cycle();
        end
        drive_idle();
        cycle();
        n_total++; if (stall_cnt !== exp_stall) $display("FAIL b2b_stall: got %h expected %h", stall_cnt, exp_stall); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d pending writes expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_saturate_and_reset();
        alu_valid = 1'b1; alu_rd = 5'd0;
        ld_valid  = 1'b1; ld_rd  = 5'd0;
        while (exp_stall != 16'hFFFF) cycle();
        #1;
        n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_max: got %h expected ffff", stall_cnt); else n_pass++;
        cycle();
        n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_sat: got %h expected ffff", stall_cnt); else n_pass++;
        drive_idle();
        iss_valid = 1'b1; iss_rd = 5'd2;
        cycle();
        iss_rd = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hFACE;
        cycle();
        drive_idle();
        n_total++; if (busy !== 32'h84) $display("FAIL pre_rst_busy: got %h expected 00000084", busy); else n_pass++;
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hBAD;
        cycle();
        n_total++; if (busy !== 32'd0 || stall_cnt !== 16'd0 || RegWEn !== 1'b0)
            $display("FAIL mid_rst: got busy=%h stall=%h regwen=%b expected 0/0/0", busy, stall_cnt, RegWEn); else n_pass++;
        exp_stall = 16'd0;
        drive_idle();
        rst_n = 1'b1;
        cycle();
        n_total++; if (RegWEn !== 1'b0) $display("FAIL post_rst_regwen: got %b expected 0", RegWEn); else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL final_drain: got %0d pending writes expected 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_collision();
        test_scoreboard();
        test_set_clear_same();
        test_x0();
        test_back_to_back();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
